// File: rtl/gray_roi_capture_if.sv
// Pixel stream, buffer read port and frame handshake between the demosaic,
// the ROI capture controller and the classifier input stage.
interface gray_roi_capture_if;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_eol;
    logic [29:0] pix_rgb;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_ready;
    logic        frame_ack;

    modport master (
        output pix_valid, pix_sof, pix_eol, pix_rgb, rd_addr, frame_ack,
        input  rd_data, frame_ready
    );

    modport slave (
        input  pix_valid, pix_sof, pix_eol, pix_rgb, rd_addr, frame_ack,
        output rd_data, frame_ready
    );
endinterface

// File: rtl/gray_roi_capture_ctrl.sv
// Converts RGB10 pixels to gray8, box-averages a square ROI into an
// OUT_DIM x OUT_DIM image buffer and hands it over with a ready/ack handshake.
//
// state    | meaning
// IDLE     | disarmed, waiting for enable
// WAIT_SOF | armed, waiting for the first pixel of a frame
// CAPTURE  | accumulating ROI blocks into the buffer
// READY    | buffer complete and frozen until frame_ack
module gray_roi_capture_ctrl #(
    parameter int IMG_W   = 640,
    parameter int ROI_X0  = 208,
    parameter int ROI_Y0  = 128,
    parameter int SCALE   = 8,
    parameter int OUT_DIM = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              busy,
    gray_roi_capture_if.slave bus
);
    localparam int LOG_S = $clog2(SCALE);
    localparam int ROI_W = OUT_DIM * SCALE;
    localparam int DEPTH = OUT_DIM * OUT_DIM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int ACC_W = 8 + 2 * LOG_S;
    localparam int PW    = 12;

    localparam logic [PW-1:0] X_LO   = PW'(ROI_X0);
    localparam logic [PW-1:0] X_HI   = PW'(ROI_X0 + ROI_W);
    localparam logic [PW-1:0] Y_LO   = PW'(ROI_Y0);
    localparam logic [PW-1:0] Y_HI   = PW'(ROI_Y0 + ROI_W);
    localparam logic [PW-1:0] X_MAX  = PW'(IMG_W - 1);
    localparam logic [PW-1:0] S_MASK = PW'(SCALE - 1);
    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
    localparam logic [9:0]    DEPTH_A = 10'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, READY} state_t;
    state_t state;

    logic [PW-1:0]    x, y, px, py, ox, oy;
    logic [11:0]      sum_rgb;
    logic [8:0]       d;
    logic [9:0]       t;
    logic [7:0]       gray;
    logic             pix_take, restart, hit, blk_last;
    logic [BW-1:0]    bx, by;

    logic             g_valid, g_last;
    logic [7:0]       g_gray;
    logic [BW-1:0]    g_bx;
    logic [AW-1:0]    g_addr;
    logic [ACC_W-1:0] acc [OUT_DIM];
    logic [ACC_W-1:0] acc_sum;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic [7:0]       mem [DEPTH];

    always_comb begin
        pix_take = bus.pix_valid &&
                   (state == CAPTURE || (state == WAIT_SOF && bus.pix_sof));
        restart  = pix_take && bus.pix_sof;
        px       = bus.pix_sof ? '0 : x;
        py       = bus.pix_sof ? '0 : y;
        sum_rgb  = {2'b0, bus.pix_rgb[29:20]} + {2'b0, bus.pix_rgb[19:10]}
                 + {2'b0, bus.pix_rgb[9:0]};
        d        = 9'(sum_rgb >> 3);
        t        = 10'(({2'b0, d} + {1'b0, d, 1'b0}) >> 1);
        gray     = (t > 10'd255) ? 8'hFF : t[7:0];
        hit      = px >= X_LO && px < X_HI && py >= Y_LO && py < Y_HI;
        ox       = px - X_LO;
        oy       = py - Y_LO;
        bx       = BW'(ox >> LOG_S);
        by       = BW'(oy >> LOG_S);
        blk_last = ((ox & S_MASK) == S_MASK) && ((oy & S_MASK) == S_MASK);
        acc_sum  = acc[g_bx] + ACC_W'(g_gray);
        wr_en    = g_valid && g_last && state == CAPTURE && !restart;
        wr_data  = 8'(acc_sum >> (2 * LOG_S));
    end

    // x/y hold the position the next pixel will take; sof overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_take) begin
            if (bus.pix_eol) begin
                x <= '0;
                y <= (py == '1) ? py : py + 1'b1;
            end else begin
                x <= (px >= X_MAX) ? X_MAX : px + 1'b1;
                y <= py;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_valid <= 1'b0;
            g_last  <= 1'b0;
            g_gray  <= '0;
            g_bx    <= '0;
            g_addr  <= '0;
        end else begin
            g_valid <= pix_take && hit;
            g_last  <= blk_last;
            g_gray  <= gray;
            g_bx    <= bx;
            g_addr  <= AW'(by) * AW'(OUT_DIM) + AW'(bx);
        end
    end

    // A restart wipes the accumulators even if an old pixel is still in flight.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
        end else if (g_valid && state == CAPTURE) begin
            acc[g_bx] <= g_last ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[g_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)                     bus.rd_data <= '0;
        else if (bus.rd_addr < DEPTH_A) bus.rd_data <= mem[bus.rd_addr[AW-1:0]];
        else                         bus.rd_data <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            bus.frame_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= WAIT_SOF;
                    busy  <= 1'b1;
                end
                WAIT_SOF: if (bus.pix_valid && bus.pix_sof) state <= CAPTURE;
                CAPTURE: if (wr_en && g_addr == LAST_A) begin
                    state           <= READY;
                    busy            <= 1'b0;
                    bus.frame_ready <= 1'b1;
                end
                READY: if (bus.frame_ack) begin
                    state           <= enable ? WAIT_SOF : IDLE;
                    busy            <= enable;
                    bus.frame_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gray_roi_capture_ctrl.sv
// Self-checking bench: streams small frames with random gaps and content and
// compares the captured image against a block-average model of the ROI.
module tb_gray_roi_capture_ctrl;
    localparam int W  = 48;
    localparam int H  = 40;
    localparam int X0 = 6;
    localparam int Y0 = 4;
    localparam int S  = 4;
    localparam int N  = 8;
    localparam int RW = N * S;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic busy;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_img [N*N];
    int   blk_sum [N*N];

    gray_roi_capture_if bus();

    gray_roi_capture_ctrl #(
        .IMG_W(W), .ROI_X0(X0), .ROI_Y0(Y0), .SCALE(S), .OUT_DIM(N)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gray_ref(input int r, input int g, input int b);
        int v;
        v = ((r + g + b) / 8) * 3 / 2;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int rnd_comp();
        return $urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(0, 300);
    endfunction

    // mode 0: uniform base; 1: random; 2: checker in block (0,0), white outside ROI
    task automatic send_frame(input int mode, input int base, input int abort_line,
                              input int first_w, input bit capture);
        int r, g, b, w;
        bit roi;
        if (capture) foreach (blk_sum[i]) blk_sum[i] = 0;
        for (int ln = 0; ln < H && ln != abort_line; ln++) begin
            w = (ln == 0) ? first_w : W;
            for (int c = 0; c < w; c++) begin
                roi = c >= X0 && c < X0 + RW && ln >= Y0 && ln < Y0 + RW;
                case (mode)
                    0: begin r = base; g = base; b = base; end
                    1: begin r = rnd_comp(); g = rnd_comp(); b = rnd_comp(); end
                    default: begin
                        if (!roi) r = 1023;
                        else if (c < X0 + S && ln < Y0 + S) r = ((ln + c) % 2 == 1) ? 1023 : 0;
                        else r = 0;
                        g = r; b = r;
                    end
                endcase
                if (capture && roi)
                    blk_sum[((ln - Y0) / S) * N + (c - X0) / S] += gray_ref(r, g, b);
                if ($urandom_range(0, 9) == 0) begin
                    bus.pix_valid = 1'b0;
                    @(negedge clk);
                end
                bus.pix_valid = 1'b1;
                bus.pix_sof   = (ln == 0 && c == 0);
                bus.pix_eol   = (c == w - 1);
                bus.pix_rgb   = {r[9:0], g[9:0], b[9:0]};
                @(negedge clk);
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_eol   = 1'b0;
        if (capture) foreach (exp_img[i]) exp_img[i] = blk_sum[i] / (S * S);
    endtask

    task automatic check_buffer(input string tag);
        for (int a = 0; a < N * N; a++) begin
            bus.rd_addr = 10'(a);
            @(negedge clk);
            chk(tag, int'(bus.rd_data), exp_img[a]);
        end
    endtask

    task automatic read_const(input string tag, input int addr, input int exp);
        bus.rd_addr = 10'(addr);
        @(negedge clk);
        chk(tag, int'(bus.rd_data), exp);
    endtask

    task automatic expect_ready(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_ready"}, int'(bus.frame_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic ack(input bit en);
        enable = en;
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        chk("ack_ready_drop", int'(bus.frame_ready), 0);
        chk("ack_busy", int'(busy), int'(en));
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_eol   = 1'b0;
        bus.pix_rgb   = '0;
        bus.rd_addr   = '0;
        bus.frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.frame_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("arm_busy", int'(busy), 1);

        // stray ack while armed changes nothing
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_busy", int'(busy), 1);
        chk("stray_ack_ready", int'(bus.frame_ready), 0);

        send_frame(0, 400, -1, W, 1'b1);
        expect_ready("uniform");
        check_buffer("uniform_buf");
        read_const("uniform_225", 37, 225);

        // buffer frozen while ready
        send_frame(1, 0, -1, W, 1'b0);
        chk("hold_ready", int'(bus.frame_ready), 1);
        check_buffer("hold_buf");
        ack(1'b1);

        send_frame(0, 1023, -1, W, 1'b1);
        expect_ready("sat");
        check_buffer("sat_buf");
        read_const("sat_255", N * N - 1, 255);
        ack(1'b1);

        send_frame(0, 0, -1, W, 1'b1);
        expect_ready("black");
        check_buffer("black_buf");
        ack(1'b1);

        send_frame(2, 0, -1, W, 1'b1);
        expect_ready("alt");
        check_buffer("alt_buf");
        read_const("alt_127", 0, 127);
        read_const("alt_other", 1, 0);
        ack(1'b1);

        // first pixel carries sof and eol: next pixel is (0,1)
        send_frame(1, 0, -1, 1, 1'b1);
        expect_ready("sof_eol");
        check_buffer("sof_eol_buf");
        ack(1'b1);

        send_frame(1, 0, 20, W, 1'b0);
        @(negedge clk);
        chk("restart_no_ready", int'(bus.frame_ready), 0);
        chk("restart_busy", int'(busy), 1);
        send_frame(1, 0, -1, W, 1'b1);
        expect_ready("restart");
        check_buffer("restart_buf");
        ack(1'b0);

        send_frame(0, 1023, -1, W, 1'b0);
        @(negedge clk);
        chk("idle_no_ready", int'(bus.frame_ready), 0);
        chk("idle_busy", int'(busy), 0);

        enable = 1'b1;
        @(negedge clk);
        send_frame(1, 0, 10, W, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(bus.frame_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rearm_busy", int'(busy), 1);
        send_frame(1, 0, -1, W, 1'b1);
        expect_ready("after_rst");
        check_buffer("after_rst_buf");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gray_roi_capture_ctrl.md
Name: gray_roi_capture_ctrl

Overview:
- Sequences the RGB10-to-gray8 conversion over an incoming camera pixel stream.
- Crops a square ROI of (OUT_DIM·SCALE)² pixels and box-averages each SCALE×SCALE block into one gray8 value.
- Stores the resulting OUT_DIM×OUT_DIM image in an internal buffer and hands it to the NN input stage with a ready/ack handshake.
- Sits between the raw10-to-RGB demosaic output and the MNIST classifier input.

Parameters:
- IMG_W, 640, active pixels per line (column counter range check).
- ROI_X0, 208, first ROI column.
- ROI_Y0, 128, first ROI line.
- SCALE, 8, block edge in pixels; power of 2, range 1..16.
- OUT_DIM, 28, output image edge.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  arm capture; sampled in IDLE only.
- pix_valid  in  1  pixel qualifier.
- pix_sof  in  1  first pixel of frame; qualified by pix_valid.
- pix_eol  in  1  last pixel of line; qualified by pix_valid.
- pix_rgb  in  30  {R[29:20], G[19:10], B[9:0]}, 10 bit each.
- rd_addr  in  10  buffer read address, row·OUT_DIM+col.
- rd_data  out  8  buffer read data, 1-cycle latency.
- frame_ready  out  1  buffer holds a complete image.
- frame_ack  in  1  consumer releases buffer.
- busy  out  1  high in WAIT_SOF and CAPTURE.

Behaviour:
- Reset: state=IDLE; frame_ready=0, busy=0, rd_data=0; all counters and accumulators cleared; buffer contents undefined. Reset mid-capture aborts immediately, with no partial frame_ready.
- Gray conversion, bit-exact, 12-bit sum:
  - s = R+G+B
  - d = s>>3
  - t = (3·d)>>1
  - gray = min(t, 255)
  - The result is registered, giving 1 cycle of latency.
- Position tracking:
  - Column counter x increments per valid pixel; it resets to 0 after pix_eol.
  - Line counter y increments on pix_eol.
  - pix_sof with pix_valid forces x=0, y=0 for that pixel.
  - x saturates at IMG_W-1 if pix_eol is missing.
- ROI hit:
  - ROI_X0 ≤ x < ROI_X0+OUT_DIM·SCALE
  - ROI_Y0 ≤ y < ROI_Y0+OUT_DIM·SCALE
- Accumulators:
  - OUT_DIM column accumulators, each 8+2·log2(SCALE) bits (14 bits at SCALE=8).
  - A ROI pixel adds its gray value to acc[(x-ROI_X0)>>log2(SCALE)].
  - On the last pixel of a block (both in-block offsets = SCALE-1), write acc>>(2·log2(SCALE)) (truncate) to buf[by·OUT_DIM+bx] and clear that acc in the same cycle.
  - The write is issued one cycle after the pixel (gray pipeline).
- FSM:
  - IDLE: enable=1 -> WAIT_SOF.
  - WAIT_SOF: pix_valid&pix_sof -> CAPTURE, and that pixel is processed.
  - CAPTURE: buffer write to address OUT_DIM²-1 -> READY on the following cycle. pix_sof seen again before completion restarts capture: accumulators clear and the new pixel counts as (0,0).
  - READY: frame_ready=1, and all pixel input is ignored. frame_ack=1 -> IDLE if enable=0, else WAIT_SOF. frame_ready drops the cycle after ack.
- busy=1 in WAIT_SOF and CAPTURE.
- Buffer:
  - 784×8 simple dual-port.
  - Reads are allowed in any state with 1-cycle latency.
  - Contents are guaranteed stable only while frame_ready=1.
- Simultaneous events:
  - frame_ack outside READY is ignored.
  - pix_eol and pix_sof together on one pixel: sof takes priority for position; the next pixel is x=0, y=1.

Test Plan:
1. Uniform frame, all pixels (400,400,400), 640×480, enable=1 -> gray 225 per pixel; frame_ready rises; all 784 rd_data = 225.
2. Saturation: pixels (1023,1023,1023) -> every buffer byte = 255; pixels (0,0,0) next frame -> 0.
3. Block average: within ROI block (0,0), alternate gray 0/255 source pixels (e.g. (0,0,0)/(1023,1023,1023)) -> buf[0] = (32·255)>>6 = 127. Pixels outside the ROI set to white do not affect any byte.
4. Handshake:
   - Second frame streamed while frame_ready=1 -> buffer unchanged.
   - frame_ack pulse with enable=1 -> frame_ready=0 the next cycle and busy=1.
   - Next frame captured correctly.
5. Restart: pix_sof injected at line 200 mid-capture -> no frame_ready from the aborted frame; the following full frame produces correct contents.
6. Reset: rst asserted during CAPTURE -> next cycle state IDLE, frame_ready=0, busy=0; re-enable -> clean capture with expected values.
